seven_segment_scan_driver: RTL
==============================

Name: seven_segment_scan_driver

Overview:
Parametrised, time-multiplexed driver for an N-digit common-anode 7-segment display, extending the single-digit hex-to-segment decoding with scanning. Each digit carries decimal point, per-digit blanking and leading-zero suppression. The block adds anti-ghosting dead-time and tear-free frame-synchronous value updates. It sits between the datapath, which presents a packed hex word, and the board display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..8)
REFRESH_DIV, 50000, clk cycles per digit slot (>=2)
DEAD_CYCLES, 2, cycles at start of each slot with all anodes off (0..REFRESH_DIV-1)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
enable  input  1  scan enable; low freezes scan and blanks display
load  input  1  one-cycle strobe: capture value_in/dp_in/blank_in
value_in  input  4*NUM_DIGITS  packed hex digits, digit 0 = LSBs (rightmost)
dp_in  input  NUM_DIGITS  decimal point per digit, 1 = lit
blank_in  input  NUM_DIGITS  force digit dark, 1 = blank
lz_suppress  input  1  1 = suppress leading zeros
seg_out  output  7  segments {g,f,e,d,c,b,a}, active-low
dp_out  output  1  decimal point, active-low
anode_out  output  NUM_DIGITS  digit select, active-low, one-hot-cold
frame_done  output  1  one-cycle pulse when the last digit slot ends

Behaviour:
- Reset (async, rst_n=0): seg_out=7'h7F, dp_out=1, anode_out=all 1s, frame_done=0, slot counter=0, digit index=0, pending and display registers cleared, pending_valid=0.
- Slot counter runs 0..REFRESH_DIV-1 while enable=1; at terminal count it wraps to 0 and the digit index increments.
- Digit index wraps NUM_DIGITS-1 -> 0. frame_done pulses in the cycle the index wraps.
- Load path: load=1 writes pending register and sets pending_valid. Repeated loads before commit: last one wins.
- Commit: at frame wrap, if pending_valid, copy pending -> display and clear pending_valid.
- Load coincident with frame wrap: the new load data commits directly to display, and pending_valid ends 0.
- Segment encoding: standard hex glyphs 0-9, A, b, C, d, E, F, active-low. For example, 0 -> 7'h40, 8 -> 7'h00, F -> 7'h0E.
- Leading-zero suppression: when lz_suppress=1, a digit is dark if it and every more-significant digit are 0. Digit 0 is never suppressed, so the value 0 shows a single "0". A digit dark through suppression also darkens its dp.
- blank_in=1: that digit's anode stays off for its whole slot.
- Dead-time: for slot counts < DEAD_CYCLES, anode_out is all 1s. seg_out/dp_out update to the new digit at slot start so they settle before the anode turns on.
- All outputs are registered. Latency is 1 clk from index/counter change to pins; value commit is visible from the next slot after the frame wrap.
- enable=0: counter and index hold; anode_out forces to all 1s on the next clk; segments hold; frame_done=0; loads still accepted into pending.
- enable 0 -> 1: scan resumes from the held counter and index.
- Reset asserted mid-frame: immediate return to reset values, and pending data is lost.

Decomposition:
- Package seven_seg_pkg holds:
  - SEG_OFF = 7'h7F constant
  - 16-entry active-low glyph table, plus function hex_to_seg(logic [3:0]) returning logic [6:0]
  - digit-index width helper localparam derived with $clog2
- Sub-module seven_seg_scan_timer contains the slot counter, digit index, dead-time flag and frame_done generation.
- The top level holds the load/commit registers, suppression logic, glyph mux and output registers.

Test Plan:
- Setup for all scenarios: NUM_DIGITS=4, REFRESH_DIV=4, DEAD_CYCLES=1.
- Reset: hold rst_n=0, then release -> seg_out=7'h7F, anode_out=4'hF, frame_done=0. First anode low (4'hE) appears 2 clk after release (dead-time + register).
- Scan: load 16'h12AF, wait 2 frames -> anode sequence E,D,B,7 with glyphs F=7'h0E, A=7'h08, 2=7'h24, 1=7'h79. frame_done pulses every 16 clk. Each slot has exactly 1 all-off cycle.
- Tear-free update: load 16'h1234 and then, mid-frame, load 16'h5678 -> current frame completes showing 1234 and the next frame shows 5678. Load 16'h9999 exactly on the frame_done cycle -> the next frame shows 9999.
- Suppression: lz_suppress=1 with value 16'h0070 -> digits 3 and 2 dark, digit 1 shows 7 (7'h78), digit 0 shows 0 (7'h40). Value 16'h0000 -> only digit 0 lit, showing 0. Add dp_in=4'b1000 -> dp stays off on suppressed digit 3.
- Enable and async reset: set blank_in=4'b0010 -> digit 1 slot has anode_out=4'hF. Drop enable during digit 2 -> anodes go to F, and on re-enable the scan resumes at digit 2. Assert rst_n low mid-slot -> outputs return to reset values asynchronously, with no clk edge needed.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display driver.
package seven_seg_pkg;

  // All segments dark (active-low).
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Upper bound on scanned digits and the index width it implies.
  localparam int unsigned MAX_DIGITS = 8;
  localparam int unsigned MAX_IDX_W  = $clog2(MAX_DIGITS);

  // Active-low glyphs {g,f,e,d,c,b,a} for 0-9, A, b, C, d, E, F.
  localparam logic [6:0] GLYPHS [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    return GLYPHS[hex];
  endfunction

  // Digit-index width; a single digit still needs a 1-bit index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seven_seg_scan_timer.sv
// Slot counter and digit index for the display scan, with dead-time flag
// and a registered end-of-frame pulse.
module seven_seg_scan_timer
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned DEAD_CYCLES = 2,
  localparam int unsigned IW         = idx_width(NUM_DIGITS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable_i,
  output logic [IW-1:0] idx_o,
  output logic          dead_o,
  output logic          frame_done_o
);

  localparam int unsigned   CW       = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          fd_q, fd_d;
  logic          slot_end, frame_wrap;

  // Next-state: advance only while enabled, wrap slot then digit index.
  always_comb begin
    slot_end   = enable_i && (cnt_q == CNT_LAST);
    frame_wrap = slot_end && (idx_q == IDX_LAST);
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    if (enable_i) begin
      if (slot_end) begin
        cnt_d = '0;
        idx_d = frame_wrap ? '0 : idx_q + IW'(1);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    fd_d = frame_wrap;
  end

  // Timer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
      fd_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      fd_q  <= fd_d;
    end
  end

  generate
    if (DEAD_CYCLES == 0) begin : g_no_dead
      assign dead_o = 1'b0;
    end else begin : g_dead
      assign dead_o = (cnt_q < CW'(DEAD_CYCLES));
    end
  endgenerate

  assign idx_o        = idx_q;
  assign frame_done_o = fd_q;

endmodule

// File: rtl/seven_segment_scan_driver.sv
// Time-multiplexed N-digit common-anode 7-segment driver with per-digit
// dp/blanking, leading-zero suppression, dead-time and frame-synchronous
// value updates.
module seven_segment_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned DEAD_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_suppress,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   anode_out,
  output logic                    frame_done
);

  localparam int unsigned IW = idx_width(NUM_DIGITS);

  logic [IW-1:0] idx_w;
  logic          dead_w;
  logic          frame_done_w;

  seven_seg_scan_timer #(
    .NUM_DIGITS (NUM_DIGITS),
    .REFRESH_DIV(REFRESH_DIV),
    .DEAD_CYCLES(DEAD_CYCLES)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable_i    (enable),
    .idx_o       (idx_w),
    .dead_o      (dead_w),
    .frame_done_o(frame_done_w)
  );

  logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d, disp_val_q, disp_val_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
  logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d, disp_blank_q, disp_blank_d;
  logic                    pend_valid_q, pend_valid_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;

  logic [3:0]              nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   sup;
  logic                    lz_run;
  logic [3:0]              cur_nib;
  logic                    cur_sup, cur_dark;

  // Pending/display update. Commit happens while frame_done is high, i.e.
  // on the edge that registers the first slot of the new frame, so the pin
  // registers below read the post-commit value (disp_*_d) in that same edge.
  always_comb begin
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    if (load) begin
      pend_val_d   = value_in;
      pend_dp_d    = dp_in;
      pend_blank_d = blank_in;
    end
    pend_valid_d = frame_done_w ? 1'b0 : (pend_valid_q | load);

    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;
    disp_blank_d = disp_blank_q;
    if (frame_done_w) begin
      if (load) begin
        disp_val_d   = value_in;
        disp_dp_d    = dp_in;
        disp_blank_d = blank_in;
      end else if (pend_valid_q) begin
        disp_val_d   = pend_val_q;
        disp_dp_d    = pend_dp_q;
        disp_blank_d = pend_blank_q;
      end
    end
  end

  // Leading-zero suppression: a zero run from the top digit down, digit 0 exempt.
  always_comb begin
    sup    = '0;
    lz_run = lz_suppress;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      nib[i] = disp_val_d[4*i +: 4];
    end
    for (int unsigned i = NUM_DIGITS - 1; i > 0; i--) begin
      lz_run = lz_run && (nib[i] == 4'h0);
      sup[i] = lz_run;
    end
    cur_nib  = nib[idx_w];
    cur_sup  = sup[idx_w];
    cur_dark = cur_sup | disp_blank_d[idx_w];
  end

  // Pin values for the digit being scanned; disabled scan blanks anodes only.
  always_comb begin
    seg_d   = seg_q;
    dp_d    = dp_q;
    anode_d = '1;
    if (enable) begin
      seg_d = cur_sup ? SEG_OFF : hex_to_seg(cur_nib);
      dp_d  = ~(disp_dp_d[idx_w] & ~cur_sup);
      if (!dead_w && !cur_dark) begin
        anode_d[idx_w] = 1'b0;
      end
    end
  end

  // Load/commit and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      pend_valid_q <= 1'b0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      disp_blank_q <= '0;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
      anode_q      <= '1;
    end else begin
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      pend_valid_q <= pend_valid_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      disp_blank_q <= disp_blank_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      anode_q      <= anode_d;
    end
  end

  assign seg_out    = seg_q;
  assign dp_out     = dp_q;
  assign anode_out  = anode_q;
  assign frame_done = frame_done_w;

endmodule
